// File: rtl/display_pkg.sv
// display_pkg: shared scheduler states and seven-segment display constants
package display_pkg;

    typedef enum logic [1:0] {IDLE, LATCH, SHOW, HOLD} state_t;

    localparam logic [3:0]  DIGIT_BLANK = 4'hF;
    localparam logic [3:0]  DIGIT_C     = 4'hC;
    localparam logic [35:0] BLANK_WORD  = {DIGIT_BLANK, {8{DIGIT_BLANK}}};

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just above ptr, wrapping
// Ports: req (N requests), ptr (last granted index), gnt (one-hot pick),
//        gnt_idx (binary pick), any (at least one request set)
module rr_arbiter
    import display_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [3:0]   gnt_idx,
    output logic         any
);

    logic [3:0] idx_hi, idx_lo;
    logic       any_hi, any_lo;

    // Scanning downward lets the lowest index in each half win; indices
    // above ptr outrank those at or below it, giving the wrap-around order.
    always_comb begin
        idx_hi = '0;
        idx_lo = '0;
        any_hi = 1'b0;
        any_lo = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j] && 4'(j) > ptr) begin
                idx_hi = 4'(j);
                any_hi = 1'b1;
            end
            if (req[j] && 4'(j) <= ptr) begin
                idx_lo = 4'(j);
                any_lo = 1'b1;
            end
        end
        any     = any_hi | any_lo;
        gnt_idx = any_hi ? idx_hi : idx_lo;
        gnt     = any ? N'(1) << gnt_idx : '0;
    end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin time-sharing of the 8-digit display with dwell and scan tick
// Ports: clk, rst (async active-low), req/data (per-source level request and
//        32-bit packed-nibble word), ack (one-cycle capture pulse),
//        ram ({source index, displayed word}), busy (LATCH/SHOW), scan_en (digit tick)
module display_scheduler
    import display_pkg::*;
#(
    parameter int N_SRC     = 3,
    parameter int DWELL_CYC = 50_000_000,
    parameter int SCAN_DIV  = 10_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     req,
    input  logic [32*N_SRC-1:0]  data,
    output logic [N_SRC-1:0]     ack,
    output logic [35:0]          ram,
    output logic                 busy,
    output logic                 scan_en
);

    localparam int DW = $clog2(DWELL_CYC);
    localparam int SW = $clog2(SCAN_DIV);

    state_t           state_q, state_d;
    logic [3:0]       ptr_q, ptr_d, gidx_q, gidx_d;
    logic [N_SRC-1:0] goh_q, goh_d, ack_q, ack_d;
    logic [35:0]      ram_q, ram_d;
    logic             busy_q, busy_d, scan_en_q, scan_en_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [SW-1:0]    scan_q, scan_d;

    logic [N_SRC-1:0] pick_oh;
    logic [3:0]       pick_idx;
    logic             pick_any;
    logic [31:0]      word;
    logic             dwell_end, scan_end;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // The registered one-hot grant selects the word to capture.
    always_comb begin
        word = '0;
        for (int i = 0; i < N_SRC; i++)
            if (goh_q[i]) word = data[32*i +: 32];
    end

    assign dwell_end = dwell_q == DW'(DWELL_CYC - 1);
    assign scan_end  = scan_q == SW'(SCAN_DIV - 1);

    // A new grant is taken from IDLE, HOLD, or the final SHOW cycle; the
    // capture and ack follow one edge later in LATCH.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        goh_d   = goh_q;
        ram_d   = ram_q;
        ack_d   = '0;
        dwell_d = dwell_q;
        if (state_q == LATCH) begin
            ram_d   = {gidx_q, word};
            ack_d   = goh_q;
            dwell_d = '0;
            state_d = SHOW;
        end else if (state_q == SHOW && !dwell_end) begin
            dwell_d = dwell_q + 1'b1;
        end else if (pick_any) begin
            state_d = LATCH;
            ptr_d   = pick_idx;
            gidx_d  = pick_idx;
            goh_d   = pick_oh;
        end else if (state_q == SHOW) begin
            state_d = HOLD;
        end
        busy_d    = state_d == LATCH || state_d == SHOW;
        scan_d    = scan_end ? '0 : scan_q + 1'b1;
        scan_en_d = scan_end;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= 4'(N_SRC - 1);
            gidx_q    <= '0;
            goh_q     <= '0;
            ram_q     <= BLANK_WORD;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            dwell_q   <= '0;
            scan_q    <= '0;
            scan_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            goh_q     <= goh_d;
            ram_q     <= ram_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            dwell_q   <= dwell_d;
            scan_q    <= scan_d;
            scan_en_q <= scan_en_d;
        end
    end

    assign ack     = ack_q;
    assign ram     = ram_q;
    assign busy    = busy_q;
    assign scan_en = scan_en_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: scoreboard bench with a cycle-arithmetic reference model
module tb_display_scheduler;

    localparam int N = 3;
    localparam int D = 8;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [2:0]   req = '0;
    logic [95:0]  data = '0;
    logic [2:0]   ack;
    logic [35:0]  ram;
    logic         busy, scan_en;

    always #5 clk = ~clk;

    display_scheduler #(.N_SRC(N), .DWELL_CYC(D), .SCAN_DIV(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .ack     (ack),
        .ram     (ram),
        .busy    (busy),
        .scan_en (scan_en)
    );

    typedef struct {
        int          src;
        logic [31:0] word;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          c = 0;
    int          ptr, next_ok, last_take, pick, lat_edge;
    bit          took, pend;
    logic [35:0] ram_exp;
    bit          busy_exp;
    bit          drop = 1'b1;
    bit          rnd = 1'b0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, c);
        end
    endtask

    function automatic int rr_pick(input logic [2:0] r, input int p);
        for (int k = 1; k <= N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        ptr      = N - 1;
        next_ok  = 0;
        took     = 1'b0;
        pend     = 1'b0;
        ram_exp  = 36'hF_FFFF_FFFF;
        busy_exp = 1'b0;
        q.delete();
    endtask

    // Reference model: a grant may be taken whenever the scheduler is free;
    // the word is captured one edge later and the next grant opportunity
    // comes DWELL cycles after that capture.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else begin
                c++;
                if (pend && c == lat_edge) begin
                    ram_exp = {4'(pick), data[32*pick +: 32]};
                    q.push_back('{pick, data[32*pick +: 32], c});
                    pend = 1'b0;
                end
                if (c >= next_ok && req != 3'b000) begin
                    pick      = rr_pick(req, ptr);
                    ptr       = pick;
                    pend      = 1'b1;
                    lat_edge  = c + 1;
                    next_ok   = c + 1 + D;
                    last_take = c;
                    took      = 1'b1;
                end
                busy_exp = took && (c <= last_take + D);
            end
        end
    end

    // Monitor: compares outputs every cycle and pops the scoreboard on ack.
    initial begin
        exp_t e;
        int   gap;
        bit   seen;
        gap  = 0;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            chk("ram", ram, ram_exp);
            chk("busy", busy, busy_exp);
            if (ack != 3'b000) begin
                if (q.size() == 0) chk("ack_unexpected", ack, 3'b000);
                else begin
                    e = q.pop_front();
                    chk("ack_src", ack, 3'b001 << e.src);
                    chk("ack_word", ram[31:0], e.word);
                    chk("ack_idx", ram[35:32], 4'(e.src));
                    chk("ack_cycle", c, e.due);
                end
            end else if (q.size() != 0 && q[0].due <= c) begin
                e = q.pop_front();
                chk("ack_missing", ack, 3'b001 << e.src);
            end
            if (!rst) begin
                seen = 1'b0;
                chk("scan_reset", scan_en, 1'b0);
            end else if (scan_en) begin
                if (seen) chk("scan_gap", gap, S);
                seen = 1'b1;
                gap  = 1;
            end else begin
                gap++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (drop) req = req & ~ack;
            if (rnd) data = {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic do_reset(input logic [2:0] r);
        @(posedge clk);
        #3;
        rst = 1'b0;
        req = r;
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram", ram, 36'hF_FFFF_FFFF);
        chk("rst_ack", ack, 3'b000);
        chk("rst_busy", busy, 1'b0);
        #2;
        rst = 1'b1;
        step(12);

        data = {32'h0, 32'h1234_5678, 32'h0};
        req  = 3'b010;
        step(20);

        do_reset(3'b111);
        step(40);

        drop = 1'b0;
        rnd  = 1'b1;
        req  = 3'b101;
        step(45);
        req = 3'b000;
        step(12);

        drop = 1'b1;
        req  = 3'b001;
        for (int k = 0; k < 40 && !ack[0]; k++) step(1);
        chk("t5_ack0_seen", ack[0], 1'b1);
        step(2);
        req[2] = 1'b1;
        step(25);

        drop = 1'b0;
        req  = 3'b011;
        step(5);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_ram", ram, 36'hF_FFFF_FFFF);
        chk("async_busy", busy, 1'b0);
        chk("async_ack", ack, 3'b000);
        req = 3'b110;
        @(posedge clk);
        #3;
        rst = 1'b1;
        step(30);

        drop = 1'b1;
        req  = 3'b000;
        for (int k = 0; k < 250; k++) begin
            step(1);
            if ($urandom_range(3) == 0) req[$urandom_range(2)] = 1'b1;
        end
        req = 3'b000;
        step(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the 8-digit seven-segment display between several result producers (primality result, operand entry, status codes) and generates the digit-scan enable for the display driver. Each requester hands over a 32-bit packed-nibble word via a req/ack handshake. Words are granted round-robin, and each granted word is held on the display for a minimum dwell time. The 36-bit `ram` output feeds the display driver directly.

## Interface
- `N_SRC`, 3: number of requesters, 1..15
- `DWELL_CYC`, 50_000_000: minimum clock cycles a granted word stays displayed, ≥2
- `SCAN_DIV`, 10_000: clock cycles per digit-scan tick, ≥2
- `clk`  input  1  system clock
- `rst`  input  1  reset; asynchronous, active-low
- `req`  input  N_SRC  per-source request, level; hold until ack
- `data`  input  32*N_SRC  source i word at [32i+31:32i]; 8 digit nibbles (0-9, C, F=blank)
- `ack`  output  N_SRC  one-cycle pulse; word of that source has been captured
- `ram`  output  36  [31:0] displayed word, [35:32] granted source index
- `busy`  output  1  high while in LATCH or SHOW
- `scan_en`  output  1  one-cycle tick every SCAN_DIV cycles, for the display driver

## Operation
- Reset values:
  - `ram` = 36'hF_FFFF_FFFF (all digits blank, index F)
  - `ack` = 0, `busy` = 0, `scan_en` = 0
  - state = IDLE, round-robin pointer = N_SRC-1, so source 0 has first priority
  - dwell and scan counters = 0
- States:
  - IDLE: no word shown yet.
  - LATCH: single cycle; the grant is already registered.
  - SHOW: dwell in progress.
  - HOLD: dwell expired; last word is retained.
- Transitions:
  - IDLE/HOLD → LATCH on any `req` bit.
  - LATCH → SHOW unconditionally.
  - SHOW → LATCH when dwell ends and any `req` bit is set; otherwise SHOW → HOLD.
- Grant selection (taken on the IDLE/HOLD/SHOW exit edge):
  - Pick the first set `req` bit scanning from pointer+1 upward, with wrap-around.
  - Store the grant index; pointer becomes the grant index.
- On the LATCH edge:
  - `ram[31:0]` ← `data` of the granted source.
  - `ram[35:32]` ← grant index, zero-extended.
  - Granted `ack` bit ← 1 for exactly one cycle; dwell counter ← 0.
- `req` arriving during LATCH or SHOW is not serviced until the dwell ends. There is no preemption.
- A requester that drops `req` during LATCH is still granted and acked; its captured word is shown.
- A requester re-asserting `req` after its ack is treated as a new request and competes fairly.
- `data` is sampled only on the LATCH edge. It need not be stable at any other time.
- `scan_en`: free-running counter over 0..SCAN_DIV-1. Pulses high during the cycle after the counter reaches SCAN_DIV-1. Independent of the state machine.
- Asynchronous reset assertion mid-operation immediately forces all reset values. Any pending or in-flight grant is discarded without an ack.

## Timing
- `req` seen on edge E0 in IDLE/HOLD: grant registered at E0; `ram` updated and `ack` high in the cycle after E1.
- SHOW lasts exactly DWELL_CYC cycles.
- Back-to-back grants: acks are exactly DWELL_CYC+1 cycles apart.
- `busy` goes high the cycle after E0 and low the cycle after the SHOW→HOLD edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `display_pkg` holds:
  - state enum (IDLE, LATCH, SHOW, HOLD)
  - `BLANK_WORD` = 36'hF_FFFF_FFFF
  - digit code constants (BLANK = 4'hF, C = 4'hC)
- Sub-module `rr_arbiter`: N-bit one-hot round-robin pick, given `req` and pointer; purely combinational.
- Counters sized with $clog2 of the respective parameter.

## Test plan
Bench parameters: N_SRC=3, DWELL_CYC=8, SCAN_DIV=4.
1. Reset, no requests → `ram`=F_FFFF_FFFF, `ack`=0, `busy`=0; `scan_en` pulses once every 4 cycles indefinitely.
2. `req[1]` with `data` word 0x1234_5678 → `ack[1]` one cycle, `ram`=1_1234_5678 in the same cycle. `busy` stays high for 9 cycles, then HOLD keeps `ram` unchanged.
3. `req`=3'b111 held from reset, each dropped on its ack → acks in order 0, 1, 2, spaced 9 cycles apart; `ram[35:32]` steps 0, 1, 2.
4. `req[0]` and `req[2]` continuously re-asserted → grants alternate 0, 2, 0, 2; source 1 is never acked.
5. `req[2]` raised 2 cycles into a source-0 SHOW → no `ack[2]` until source-0 dwell ends. `ack[2]` arrives 9 cycles after `ack[0]`.
6. `rst` pulled low between edges mid-SHOW → `ram`=F_FFFF_FFFF and `busy`=0 immediately. After release with `req`=3'b110, source 1 is granted first.
